// File: rtl/ldpc_edge_addr_gen.sv
// Run-time LDPC edge-address generator: a writable MB x NB base table (present + shift) is walked
// row-major (check-node order) or column-major (bit-node order), emitting up to LANES edges per beat.
module ldpc_edge_addr_gen #(
  parameter  int Z       = 96,
  parameter  int MB      = 12,
  parameter  int NB      = 24,
  parameter  int LANES   = 8,
  localparam int MAXU    = (MB > NB) ? MB : NB,
  localparam int SHIFT_W = $clog2(Z),
  localparam int IDX_W   = $clog2(MAXU * Z),
  localparam int BR_W    = $clog2(LANES),
  localparam int CA_W    = $clog2(MB * NB),
  localparam int U_W     = $clog2(MAXU)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_cfg_we,
  input  logic [CA_W-1:0]          i_cfg_addr,
  input  logic                     i_cfg_present,
  input  logic [SHIFT_W-1:0]       i_cfg_shift,
  output logic                     o_cfg_err,
  input  logic                     i_start,
  input  logic                     i_mode,
  output logic                     o_busy,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES-1:0]         o_lane_valid,
  output logic [LANES*IDX_W-1:0]   o_index,
  output logic [LANES*BR_W-1:0]    o_branch,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic                     o_overflow,
  output logic [1:0]               o_dbg_state
);

  // Handshake: a beat transfers on a cycle where o_valid && i_ready; while o_valid && !i_ready every
  // beat output holds its value, and the beat counter only advances on a transfer.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2} state_t;

  localparam logic [SHIFT_W:0]   ZW   = (SHIFT_W+1)'(Z);
  localparam logic [SHIFT_W-1:0] KMAX = SHIFT_W'(Z - 1);

  state_t               state_q;
  logic                 mode_q;
  logic [U_W-1:0]       unit_q;
  logic [SHIFT_W-1:0]   k_q;
  logic [MB*NB-1:0]     present_q;
  logic [SHIFT_W-1:0]   shift_q [MB*NB];
  logic [IDX_W-1:0]     lane_base_q [LANES];
  logic [SHIFT_W-1:0]   lane_shift_q [LANES];
  logic                 valid_q, sof_q, eof_q, overflow_q, cfg_err_q;
  logic [LANES-1:0]     lane_valid_q;
  logic [LANES*IDX_W-1:0] index_q;
  logic [LANES*BR_W-1:0]  branch_q;

  logic                 cfg_bad, last_unit;
  logic [LANES-1:0]     ld_v;
  logic [IDX_W-1:0]     ld_base [LANES];
  logic [SHIFT_W-1:0]   ld_shift [LANES];
  logic [BR_W-1:0]      ld_br [LANES];
  logic                 ld_ovf;
  logic [SHIFT_W-1:0]   nxt_k;
  logic [LANES*IDX_W-1:0] nxt_index;

  assign cfg_bad   = (state_q != ST_IDLE) || (int'(i_cfg_shift) >= Z) || (int'(i_cfg_addr) >= MB * NB);
  assign last_unit = mode_q ? (unit_q == U_W'(NB - 1)) : (unit_q == U_W'(MB - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      present_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= i_cfg_we && cfg_bad;
      if (i_cfg_we && !cfg_bad) present_q[i_cfg_addr] <= i_cfg_present;
    end
  end

  // Shift values are meaningless while the present bit is clear, so they need no reset.
  always_ff @(posedge i_clock) begin
    if (i_cfg_we && !cfg_bad) shift_q[i_cfg_addr] <= i_cfg_shift;
  end

  // Compact the present entries of the current unit into lanes and rank it in each crossing unit.
  always_comb begin : load_compact
    int cnt;
    int rk;
    logic [CA_W-1:0] a;
    cnt    = 0;
    rk     = 0;
    a      = '0;
    ld_v   = '0;
    ld_ovf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      ld_base[l]  = '0;
      ld_shift[l] = '0;
      ld_br[l]    = '0;
    end
    if (!mode_q) begin
      for (int c = 0; c < NB; c++) begin
        a = CA_W'(int'(unit_q) * NB + c);
        if (present_q[a]) begin
          rk = 0;
          for (int r = 0; r < MB; r++)
            if (r < int'(unit_q) && present_q[CA_W'(r * NB + c)]) rk++;
          if (cnt < LANES) begin
            ld_v[BR_W'(cnt)]     = 1'b1;
            ld_base[BR_W'(cnt)]  = IDX_W'(c * Z);
            ld_shift[BR_W'(cnt)] = shift_q[a];
            ld_br[BR_W'(cnt)]    = BR_W'((rk > LANES - 1) ? LANES - 1 : rk);
          end
          cnt++;
        end
      end
    end else begin
      for (int r = 0; r < MB; r++) begin
        a = CA_W'(r * NB + int'(unit_q));
        if (present_q[a]) begin
          rk = 0;
          for (int c = 0; c < NB; c++)
            if (c < int'(unit_q) && present_q[CA_W'(r * NB + c)]) rk++;
          if (cnt < LANES) begin
            ld_v[BR_W'(cnt)]     = 1'b1;
            ld_base[BR_W'(cnt)]  = IDX_W'(r * Z);
            ld_shift[BR_W'(cnt)] = shift_q[a];
            ld_br[BR_W'(cnt)]    = BR_W'((rk > LANES - 1) ? LANES - 1 : rk);
          end
          cnt++;
        end
      end
    end
    ld_ovf = (cnt > LANES);
  end

  // Next beat: k=0 straight from the LOAD result, otherwise k+1 from the latched lanes.
  always_comb begin : beat_calc
    logic                 v;
    logic [IDX_W-1:0]     base;
    logic [SHIFT_W-1:0]   s;
    logic [SHIFT_W:0]     sum, off;
    nxt_k     = (state_q == ST_LOAD) ? '0 : k_q + SHIFT_W'(1);
    nxt_index = '0;
    v         = 1'b0;
    base      = '0;
    s         = '0;
    sum       = '0;
    off       = '0;
    for (int l = 0; l < LANES; l++) begin
      v    = (state_q == ST_LOAD) ? ld_v[l]     : lane_valid_q[l];
      base = (state_q == ST_LOAD) ? ld_base[l]  : lane_base_q[l];
      s    = (state_q == ST_LOAD) ? ld_shift[l] : lane_shift_q[l];
      sum  = {1'b0, nxt_k} + {1'b0, s};
      if (!mode_q) off = (sum >= ZW) ? sum - ZW : sum;
      else         off = (nxt_k >= s) ? {1'b0, nxt_k - s} : {1'b0, nxt_k} + ZW - {1'b0, s};
      nxt_index[l*IDX_W +: IDX_W] = v ? base + IDX_W'(off) : '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      unit_q       <= '0;
      k_q          <= '0;
      valid_q      <= 1'b0;
      lane_valid_q <= '0;
      index_q      <= '0;
      branch_q     <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      overflow_q   <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        lane_base_q[l]  <= '0;
        lane_shift_q[l] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            mode_q  <= i_mode;
            unit_q  <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          for (int l = 0; l < LANES; l++) begin
            lane_base_q[l]              <= ld_base[l];
            lane_shift_q[l]             <= ld_shift[l];
            branch_q[l*BR_W +: BR_W]    <= ld_br[l];
          end
          lane_valid_q <= ld_v;
          index_q      <= nxt_index;
          valid_q      <= 1'b1;
          k_q          <= '0;
          sof_q        <= (unit_q == '0);
          eof_q        <= (nxt_k == KMAX) && last_unit;
          if (ld_ovf) overflow_q <= 1'b1;
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          if (i_ready) begin
            if (k_q == KMAX) begin
              valid_q      <= 1'b0;
              lane_valid_q <= '0;
              sof_q        <= 1'b0;
              eof_q        <= 1'b0;
              if (last_unit) begin
                unit_q  <= '0;
                state_q <= ST_IDLE;
              end else begin
                unit_q  <= unit_q + U_W'(1);
                state_q <= ST_LOAD;
              end
            end else begin
              k_q     <= nxt_k;
              index_q <= nxt_index;
              sof_q   <= 1'b0;
              eof_q   <= (nxt_k == KMAX) && last_unit;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_cfg_err    = cfg_err_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_valid      = valid_q;
  assign o_lane_valid = lane_valid_q;
  assign o_index      = index_q;
  assign o_branch     = branch_q;
  assign o_sof        = sof_q;
  assign o_eof        = eof_q;
  assign o_overflow   = overflow_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_ldpc_edge_addr_gen.sv
// Bench for ldpc_edge_addr_gen: a queue-based reference of the base-table walk checks every
// transferred beat, stall stability, LOAD bubbles, config rejection, overflow and mid-pass reset.
module tb_ldpc_edge_addr_gen;
  localparam int Z = 96, MB = 12, NB = 24, LANES = 8;
  localparam int SHIFT_W = $clog2(Z);
  localparam int IDX_W   = $clog2(NB * Z);
  localparam int BR_W    = $clog2(LANES);
  localparam int CA_W    = $clog2(MB * NB);
  localparam int BW      = 2 + LANES + LANES * BR_W + LANES * IDX_W;

  logic clk = 1'b0;
  logic i_reset, i_cfg_we, i_cfg_present, i_start, i_mode, i_ready;
  logic [CA_W-1:0]        i_cfg_addr;
  logic [SHIFT_W-1:0]     i_cfg_shift;
  logic                   o_cfg_err, o_busy, o_valid, o_sof, o_eof, o_overflow;
  logic [LANES-1:0]       o_lane_valid;
  logic [LANES*IDX_W-1:0] o_index;
  logic [LANES*BR_W-1:0]  o_branch;
  logic [1:0]             o_dbg_state;

  ldpc_edge_addr_gen #(.Z(Z), .MB(MB), .NB(NB), .LANES(LANES)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_present(i_cfg_present), .i_cfg_shift(i_cfg_shift), .o_cfg_err(o_cfg_err),
    .i_start(i_start), .i_mode(i_mode), .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
    .o_lane_valid(o_lane_valid), .o_index(o_index), .o_branch(o_branch), .o_sof(o_sof),
    .o_eof(o_eof), .o_overflow(o_overflow), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] cap[$];
  logic [BW-1:0] ref_cap[$];
  bit  pres [MB][NB];
  int  shf  [MB][NB];
  int  beat_no = 0;
  int  bubbles = 0;
  bit  chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [BW-1:0] b, input int l);
    return int'(b[l*IDX_W +: IDX_W]);
  endfunction
  function automatic int br_of(input logic [BW-1:0] b, input int l);
    return int'(b[LANES*IDX_W + l*BR_W +: BR_W]);
  endfunction
  function automatic int lv_of(input logic [BW-1:0] b);
    return int'(b[LANES*IDX_W + LANES*BR_W +: LANES]);
  endfunction

  function automatic logic [BW-1:0] mask_of(input logic [LANES-1:0] lv);
    logic [BW-1:0] m;
    m = '0;
    m[BW-1 -: 2 + LANES] = '1;
    for (int l = 0; l < LANES; l++)
      if (lv[l]) begin
        m[l*IDX_W +: IDX_W] = '1;
        m[LANES*IDX_W + l*BR_W +: BR_W] = '1;
      end
    return m;
  endfunction

  // ---------------- reference model ----------------
  task automatic build_exp(input int mode);
    int ents[$];
    logic [LANES-1:0]       lv;
    logic [LANES*BR_W-1:0]  br;
    logic [LANES*IDX_W-1:0] ix;
    int units, rk, pos, s, off;
    units = (mode == 0) ? MB : NB;
    for (int u = 0; u < units; u++) begin
      ents.delete();
      if (mode == 0) begin
        for (int c = 0; c < NB; c++) if (pres[u][c]) ents.push_back(c);
      end else begin
        for (int r = 0; r < MB; r++) if (pres[r][u]) ents.push_back(r);
      end
      for (int k = 0; k < Z; k++) begin
        lv = '0; br = '0; ix = '0;
        for (int l = 0; l < ents.size() && l < LANES; l++) begin
          pos = ents[l];
          rk  = 0;
          if (mode == 0) begin
            for (int r = 0; r < u; r++) if (pres[r][pos]) rk++;
            s   = shf[u][pos];
            off = (k + s) % Z;
          end else begin
            for (int c = 0; c < u; c++) if (pres[pos][c]) rk++;
            s   = shf[pos][u];
            off = (k - s + Z) % Z;
          end
          lv[l] = 1'b1;
          ix[l*IDX_W +: IDX_W] = IDX_W'(pos * Z + off);
          br[l*BR_W +: BR_W]   = BR_W'((rk < LANES) ? rk : LANES - 1);
        end
        exp_q.push_back({(u == 0 && k == 0), (u == units - 1 && k == Z - 1), lv, br, ix});
      end
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic [BW-1:0] cur, held, e, m;
    bit hold_chk;
    hold_chk = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {o_sof, o_eof, o_lane_valid, o_branch, o_index};
      if (chk_en) begin
        if (hold_chk) begin
          total++;
          if (cur !== held) begin
            bad++;
            $display("FAIL hold beat %0d: got %h want %h", beat_no, cur, held);
          end
        end
        if (o_busy && !o_valid) bubbles++;
        if (o_valid && i_ready) begin
          cap.push_back(cur);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_beat %0d: got %h want none", beat_no, cur);
          end else begin
            e = exp_q.pop_front();
            m = mask_of(e[LANES*IDX_W + LANES*BR_W +: LANES]);
            if ((cur & m) !== (e & m)) begin
              bad++;
              $display("FAIL beat %0d: got %h want %h", beat_no, cur & m, e & m);
            end
          end
          beat_no++;
        end
        hold_chk = o_valid && !i_ready;
        held = cur;
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    for (int r = 0; r < MB; r++)
      for (int c = 0; c < NB; c++) begin
        pres[r][c] = 1'b0;
        shf[r][c]  = 0;
      end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    clear_model();
    check("rst_valid", int'(o_valid), 0);
    check("rst_overflow", int'(o_overflow), 0);
  endtask

  task automatic cfg_write(input int addr, input bit p, input int sh, input bit exp_err);
    @(posedge clk); #1;
    i_cfg_we = 1'b1; i_cfg_addr = CA_W'(addr); i_cfg_present = p; i_cfg_shift = SHIFT_W'(sh);
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
    check("cfg_err", int'(o_cfg_err), int'(exp_err));
    if (!exp_err) begin
      pres[addr / NB][addr % NB] = p;
      shf[addr / NB][addr % NB]  = sh;
    end
    @(posedge clk); #1;
    check("cfg_err_clr", int'(o_cfg_err), 0);
  endtask

  task automatic run_pass(input int mode, input bit rnd, input int busy_wr_at, input int abort_at,
                          input int sw_addr, input bit sw_p, input int sw_sh);
    int cyc, units;
    bit done, aborted;
    units = (mode == 0) ? MB : NB;
    if (sw_addr >= 0) begin
      pres[sw_addr / NB][sw_addr % NB] = sw_p;
      shf[sw_addr / NB][sw_addr % NB]  = sw_sh;
    end
    exp_q.delete();
    build_exp(mode);
    cap.delete();
    beat_no = 0;
    bubbles = 0;
    chk_en  = 1'b1;
    @(posedge clk); #1;
    i_mode  = mode[0];
    i_start = 1'b1;
    if (sw_addr >= 0) begin
      i_cfg_we = 1'b1; i_cfg_addr = CA_W'(sw_addr); i_cfg_present = sw_p; i_cfg_shift = SHIFT_W'(sw_sh);
    end
    @(posedge clk); #1;
    i_start  = 1'b0;
    i_cfg_we = 1'b0;
    if (sw_addr >= 0) check("start_wr_err", int'(o_cfg_err), 0);
    @(negedge clk);
    check("load_valid", int'(o_valid), 0);
    check("load_busy", int'(o_busy), 1);
    @(negedge clk);
    check("first_valid", int'(o_valid), 1);
    cyc = 0; done = 1'b0; aborted = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && beat_no >= abort_at) begin
        chk_en  = 1'b0;
        i_reset = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", int'(o_valid), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_overflow", int'(o_overflow), 0);
        i_reset = 1'b0;
        clear_model();
        exp_q.delete();
        aborted = 1'b1;
        done = 1'b1;
      end else if (!o_busy) begin
        done = 1'b1;
      end else if (cyc > 20000) begin
        check("pass_timeout", cyc, 0);
        done = 1'b1;
      end else begin
        if (rnd) i_ready = 1'($urandom_range(0, 1));
        if (cyc == busy_wr_at) begin
          i_cfg_we = 1'b1; i_cfg_addr = CA_W'(3); i_cfg_present = 1'b0; i_cfg_shift = '0;
          i_start  = 1'b1;
        end
        if (busy_wr_at >= 0 && cyc == busy_wr_at + 1) begin
          i_cfg_we = 1'b0;
          i_start  = 1'b0;
          check("busy_wr_err", int'(o_cfg_err), 1);
        end
      end
    end
    i_ready = 1'b1;
    chk_en  = 1'b0;
    if (!aborted) begin
      check("beats_left", exp_q.size(), 0);
      check("bubbles", bubbles, units);
    end
  endtask

  function automatic int seq_diff();
    int d;
    d = 0;
    if (cap.size() != ref_cap.size()) d = 1;
    else for (int i = 0; i < cap.size(); i++) if (cap[i] !== ref_cap[i]) d++;
    return d;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    i_reset = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_present = 1'b0; i_cfg_shift = '0;
    i_start = 1'b0; i_mode = 1'b0; i_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(o_valid), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_overflow", int'(o_overflow), 0);
    check("reset_cfg_err", int'(o_cfg_err), 0);
    check("reset_lane_valid", int'(o_lane_valid), 0);
    check("reset_sof_eof", int'({o_sof, o_eof}), 0);

    // two circulants in row 0, row-major walk
    cfg_write(0 * NB + 3, 1'b1, 5, 1'b0);
    cfg_write(0 * NB + 7, 1'b1, 95, 1'b0);
    run_pass(0, 1'b0, -1, -1, -1, 1'b0, 0);
    check("m0_beats", beat_no, 1152);
    check("m0_b0_l0", idx_of(cap[0], 0), 293);
    check("m0_b0_l1", idx_of(cap[0], 1), 767);
    check("m0_b0_lv", lv_of(cap[0]), 3);
    check("m0_b0_sof", int'(cap[0][BW-1]), 1);
    check("m0_b1_l1", idx_of(cap[1], 1), 672);
    check("m0_last_eof", int'(cap[1151][BW-2]), 1);
    ref_cap = cap;

    // same table, column-major walk
    run_pass(1, 1'b0, -1, -1, -1, 1'b0, 0);
    check("m1_beats", beat_no, 2304);
    check("m1_c3_b0_idx", idx_of(cap[288], 0), 91);
    check("m1_c3_b0_br", br_of(cap[288], 0), 0);
    check("m1_c3_b5_idx", idx_of(cap[293], 0), 0);
    check("m1_c7_b0_idx", idx_of(cap[672], 0), 1);
    check("m1_c7_b0_br", br_of(cap[672], 0), 1);

    // random back-pressure must not change the beat stream
    run_pass(0, 1'b1, -1, -1, -1, 1'b0, 0);
    check("rnd_beats", beat_no, 1152);
    check("rnd_same_seq", seq_diff(), 0);

    // rejected writes: shift out of range, address out of range, and while busy
    cfg_write(3, 1'b1, 96, 1'b1);
    cfg_write(MB * NB, 1'b1, 5, 1'b1);
    run_pass(0, 1'b0, 300, -1, -1, 1'b0, 0);
    check("err_same_seq", seq_diff(), 0);

    // overflow: row 0 holds nine circulants
    do_reset();
    for (int c = 0; c < 9; c++) cfg_write(c, 1'b1, c * 10, 1'b0);
    cfg_write(2 * NB + 3, 1'b1, 1, 1'b0);
    run_pass(0, 1'b0, -1, -1, -1, 1'b0, 0);
    check("ovf_flag", int'(o_overflow), 1);
    check("ovf_lv", lv_of(cap[0]), 255);
    check("ovf_lane7", idx_of(cap[0], 7), 742);
    check("ovf_r2_idx", idx_of(cap[2 * Z], 0), 289);
    check("ovf_r2_br", br_of(cap[2 * Z], 0), 1);

    // reset in the middle of a pass, then a pass over the cleared table
    run_pass(0, 1'b0, -1, 500, -1, 1'b0, 0);
    run_pass(0, 1'b0, -1, -1, -1, 1'b0, 0);
    check("clr_beats", beat_no, 1152);
    check("clr_lv", lv_of(cap[0]), 0);

    // re-config with the final write landing in the start cycle
    cfg_write(3, 1'b1, 5, 1'b0);
    run_pass(0, 1'b0, -1, -1, 7, 1'b1, 95);
    check("recfg_same_seq", seq_diff(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
